count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 123 ++++++++++++
 tb/tb_count_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Start/stop count sequencer: IDLE -> RUN -> DONE with one-shot or auto-reload terminal count.
// Optional clock prescaler compiled in with `define COUNT_SEQ_PRESCALE_EN.
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (PRESCALE < 2) begin : g_prescale_check
    $error("count_sequencer: PRESCALE must be 2 or more");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             step;

`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;

  // Prescaler only advances in RUN, so it is already zero on every entry to RUN.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN && !stop) begin
      presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign step = (state_q == RUN) && (presc_q == PW'(PRESCALE - 1));
`else
  assign step = (state_q == RUN);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    cnt_en   = 1'b0;
    tc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          period_d = period;
          mode_d   = mode;
          count_d  = '0;
          state_d  = (period == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // stop suppresses a coincident terminal count entirely
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (step) begin
          cnt_en = 1'b1;
          if (count_q == period_q) begin
            tc      = 1'b1;
            count_d = '0;
            if (mode_q) begin
              period_d = period;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer (default build, no prescaler).
// Expected output vectors {cnt_en,count,tc,busy,done} are queued per cycle and checked mid-cycle.
module tb_count_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             cnt_en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  count_sequencer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .period (period),
    .cnt_en (cnt_en),
    .count  (count),
    .tc     (tc),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack(input logic en, input logic [3:0] c, input logic t,
                                      input logic b, input logic d);
    return {en, c, t, b, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%b expected=%b (cnt_en,count,tc,busy,done)", tag, got[7:0], want[7:0]);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, queue what that cycle must show.
  task automatic applyStimulus(input logic s, input logic p, input logic m, input logic [3:0] per,
                               input string tag, input logic [7:0] exp_v);
    exp_t e;
    @(posedge clk);
    #1;
    start  = s;
    stop   = p;
    mode   = m;
    period = per;
    e.tag  = tag;
    e.v    = exp_v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, {24'd0, pack(cnt_en, count, tc, busy, done)}, {24'd0, e.v});
    end
  end

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = 1'b0;
    period = '0;
    #2;
    checkOutput("reset_state", {24'd0, pack(cnt_en, count, tc, busy, done)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot period=3; mid-run start/period/mode changes and start in DONE are ignored
    applyStimulus(1, 0, 0, 4'd3, "os_c0",           pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd3, "os_c1",           pack(1, 4'd0, 0, 1, 0));
    applyStimulus(1, 0, 1, 4'd7, "os_c2_ign_start", pack(1, 4'd1, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd7, "os_c3",           pack(1, 4'd2, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd7, "os_c4_tc",        pack(1, 4'd3, 1, 1, 0));
    applyStimulus(1, 0, 1, 4'd7, "os_c5_done",      pack(0, 4'd0, 0, 1, 1));
    applyStimulus(0, 0, 0, 4'd0, "os_c6_idle",      pack(0, 4'd0, 0, 0, 0));

    // Auto-reload period=2, live period drops to 1 during the first pass
    applyStimulus(1, 0, 1, 4'd2, "ar_c0",      pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c1",      pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c2",      pack(1, 4'd1, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c3_tc",   pack(1, 4'd2, 1, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c4",      pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c5_tc",   pack(1, 4'd1, 1, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c6",      pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 1, 4'd1, "ar_c7_tc",   pack(1, 4'd1, 1, 1, 0));
    applyStimulus(0, 1, 1, 4'd1, "ar_c8_stop", pack(0, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 0, 4'd1, "ar_c9_idle", pack(0, 4'd0, 0, 0, 0));

    // stop coincident with terminal count
    applyStimulus(1, 0, 0, 4'd1, "st_c0",         pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd1, "st_c1",         pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 1, 0, 4'd1, "st_c2_stop_tc", pack(0, 4'd1, 0, 1, 0));
    applyStimulus(0, 0, 0, 4'd1, "st_c3_idle",    pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd1, "st_c4_nodone",  pack(0, 4'd0, 0, 0, 0));

    // period=0 goes straight to DONE
    applyStimulus(1, 0, 0, 4'd0, "p0_c0",      pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd0, "p0_c1_done", pack(0, 4'd0, 0, 1, 1));
    applyStimulus(0, 0, 0, 4'd0, "p0_c2_idle", pack(0, 4'd0, 0, 0, 0));

    // start and stop together in IDLE
    applyStimulus(1, 1, 0, 4'd3, "ss_c0", pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd3, "ss_c1", pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd3, "ss_c2", pack(0, 4'd0, 0, 0, 0));

    // Maximum period: all-ones wraps to zero
    applyStimulus(1, 0, 0, 4'd15, "max_c0", pack(0, 4'd0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 4'd15, $sformatf("max_c%0d", i + 1),
                    pack(1, 4'(i), (i == 15), 1, 0));
    end
    applyStimulus(0, 0, 0, 4'd15, "max_done", pack(0, 4'd0, 0, 1, 1));
    applyStimulus(0, 0, 0, 4'd15, "max_idle", pack(0, 4'd0, 0, 0, 0));

    // Asynchronous reset mid-RUN, then a fresh sequence
    applyStimulus(1, 0, 0, 4'd5, "rs_c0", pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd5, "rs_c1", pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 0, 4'd5, "rs_c2", pack(1, 4'd1, 0, 1, 0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", {24'd0, pack(cnt_en, count, tc, busy, done)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 4'd2, "rs_idle",    pack(0, 4'd0, 0, 0, 0));
    applyStimulus(1, 0, 0, 4'd2, "rs2_c0",     pack(0, 4'd0, 0, 0, 0));
    applyStimulus(0, 0, 0, 4'd2, "rs2_c1",     pack(1, 4'd0, 0, 1, 0));
    applyStimulus(0, 0, 0, 4'd2, "rs2_c2",     pack(1, 4'd1, 0, 1, 0));
    applyStimulus(0, 0, 0, 4'd2, "rs2_c3_tc",  pack(1, 4'd2, 1, 1, 0));
    applyStimulus(0, 0, 0, 4'd2, "rs2_c4_done", pack(0, 4'd0, 0, 1, 1));
    applyStimulus(0, 0, 0, 4'd2, "rs2_c5_idle", pack(0, 4'd0, 0, 0, 0));

    @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
